// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller.
//   state_t              : controller FSM encoding (IDLE/EXEC/RESP)
//   CARRY_BIT/ZERO_BIT/OVF_BIT : flag positions, counted upward from bit WIDTH
//                          of the packed response word
//   FLAG_W, resp_w()     : packed response width is result width plus flags
package alu_share_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CARRY_BIT = 0;
  localparam int ZERO_BIT  = 1;
  localparam int OVF_BIT   = 2;
  localparam int FLAG_W    = 3;

  function automatic int resp_w(input int width);
    return width + FLAG_W;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-request round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request lines
//   en         : grants may be issued this cycle
//   gnt[1:0]   : one-hot grant (combinational)
// The priority pointer names the favoured requester on a tie; it flips to
// the other requester only when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Granting requester 0 favours requester 1 next time, and vice versa.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= 1'b0;
    else if (|gnt)
      ptr <= gnt[0];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational ALU between two
// requesters.
//   req0_* / req1_* : valid/ready operation channels (a, b, op)
//   alu_*           : operands to the ALU and its result/flags back
//   resp_*          : valid/ready response, resp_data = {ovf, zero, carry, result}
//   busy            : controller is not idle
// Accept in IDLE, drive the ALU for one EXEC cycle, capture in RESP and hold
// until the consumer takes the word.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH+2:0] resp_data,
  output logic             busy
);

  localparam int RW = resp_w(WIDTH);

  state_t state, state_nxt;

  logic [1:0]       gnt;
  logic             accept;
  logic [WIDTH-1:0] opnd_a_p0, opnd_b_p0;
  logic [OPW-1:0]   opnd_op_p0;
  logic             opnd_id_p0;
  logic [RW-1:0]    resp_data_p1;
  logic             resp_id_p1;
  logic [RW-1:0]    packed_res;

  // Gated by reset so the ready lines read as 0 while reset is asserted.
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .en    ((state == IDLE) && !reset),
    .gnt   (gnt)
  );

  assign accept     = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    packed_res                  = '0;
    packed_res[WIDTH-1:0]       = alu_result;
    packed_res[WIDTH+CARRY_BIT] = alu_carry;
    packed_res[WIDTH+ZERO_BIT]  = alu_zero;
    packed_res[WIDTH+OVF_BIT]   = alu_overflow;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: operands latched on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      opnd_a_p0  <= '0;
      opnd_b_p0  <= '0;
      opnd_op_p0 <= '0;
      opnd_id_p0 <= 1'b0;
    end else if (accept) begin
      opnd_a_p0  <= gnt[1] ? req1_a  : req0_a;
      opnd_b_p0  <= gnt[1] ? req1_b  : req0_b;
      opnd_op_p0 <= gnt[1] ? req1_op : req0_op;
      opnd_id_p0 <= gnt[1];
    end
  end

  // p1: ALU result captured at the end of EXEC, held through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data_p1 <= '0;
      resp_id_p1   <= 1'b0;
    end else if (state == EXEC) begin
      resp_data_p1 <= packed_res;
      resp_id_p1   <= opnd_id_p0;
    end
  end

  assign alu_a      = opnd_a_p0;
  assign alu_b      = opnd_b_p0;
  assign alu_op     = opnd_op_p0;
  assign resp_data  = resp_data_p1;
  assign resp_id    = resp_id_p1;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU answers the DUT's alu_* port,
// accepted operations are queued with their expected response word, and
// responses are popped and compared as the consumer takes them.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_overflow, alu_zero, alu_carry;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [34:0] resp_data;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
  );

  // ALU: 0 ADD, 2 AND, 3 OR, 4 XOR; returns {ovf, zero, carry, result}
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      default: r = a & b;
    endcase
    return {v, (r == 32'd0), c, r};
  endfunction

  always_comb {alu_overflow, alu_zero, alu_carry, alu_result} = alu_model(alu_a, alu_b, alu_op);

  typedef struct {
    logic        id;
    logic [34:0] data;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   gid[$];
  int   gcyc[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   head_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard activity sampled at the falling edge, then return
  // just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (req0_valid && req0_ready) begin
        e.id = 1'b0; e.data = alu_model(req0_a, req0_b, req0_op); e.acc = cyc;
        sb.push_back(e); gid.push_back(0); gcyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        e.id = 1'b1; e.data = alu_model(req1_a, req1_b, req1_op); e.acc = cyc;
        sb.push_back(e); gid.push_back(1); gcyc.push_back(cyc);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_resp", 64'(resp_valid), 64'd0);
        end else begin
          if (!head_seen) begin
            chk("latency", 64'(cyc), 64'(sb[0].acc + 2));
            head_seen = 1'b1;
          end
          if (resp_ready) begin
            chk("sb_id", 64'(resp_id), 64'(sb[0].id));
            chk("sb_data", 64'(resp_data), 64'(sb[0].data));
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    int n;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    n = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin
      tick();
      #1;
      n++;
    end
    chk(id ? "grant1" : "grant0", 64'(id ? req1_ready : req0_ready), 64'd1);
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid && n < 10) begin
      tick();
      n++;
    end
    chk("resp_arrives", 64'(resp_valid), 64'd1);
  endtask

  initial begin
    reset = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    tick(); tick();
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    reset = 1'b0;
    tick();

    // single ADD from requester 0
    issue(1'b0, 32'd5, 32'd3, 3'd0);
    chk("t1_busy_exec", 64'(busy), 64'd1);
    chk("t1_ready_exec", 64'(req0_ready), 64'd0);
    chk("t1_alu_a", 64'(alu_a), 64'd5);
    chk("t1_alu_b", 64'(alu_b), 64'd3);
    tick();
    chk("t1_resp_valid", 64'(resp_valid), 64'd1);
    chk("t1_resp_id", 64'(resp_id), 64'd0);
    chk("t1_resp_data", 64'(resp_data), 64'h8);
    tick();
    chk("t1_resp_drop", 64'(resp_valid), 64'd0);

    // both requesters continuously valid
    gid.delete(); gcyc.delete();
    req0_a = 32'd100;   req0_b = 32'd23;    req0_op = 3'd0;
    req1_a = 32'hF0F0;  req1_b = 32'h0FF0;  req1_op = 3'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (13) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    chk("t2_grants", 64'(gid.size() >= 4), 64'd1);
    for (int i = 1; i < gid.size(); i++) begin
      chk("t2_alternate", 64'(gid[i]), 64'(gid[i-1] ^ 1));
      chk("t2_gap", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
    end

    // flag boundaries
    issue(1'b1, 32'h7FFF_FFFF, 32'd1, 3'd0);
    wait_resp();
    chk("t3_ovf", 64'(resp_data), {29'd0, 3'b100, 32'h8000_0000});
    tick();
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 3'd0);
    wait_resp();
    chk("t3_carry_zero", 64'(resp_data), {29'd0, 3'b011, 32'h0});
    tick();

    // back-pressure on the response channel
    resp_ready = 1'b0;
    issue(1'b1, 32'h1234, 32'h00FF, 3'd2);
    req0_a = 32'd9; req0_b = 32'd9; req0_op = 3'd0; req0_valid = 1'b1;
    wait_resp();
    repeat (5) begin
      chk("t4_hold_data", 64'(resp_data), 64'(alu_model(32'h1234, 32'h00FF, 3'd2)));
      chk("t4_hold_id", 64'(resp_id), 64'd1);
      chk("t4_no_ready", 64'(req0_ready), 64'd0);
      chk("t4_busy", 64'(busy), 64'd1);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    chk("t4_accepted", 64'(busy), 64'd1);
    wait_resp();
    tick();

    // reset during EXEC discards the operation
    issue(1'b0, 32'hDEAD, 32'd1, 3'd0);
    chk("t5_in_exec", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    sb.delete();
    head_seen = 1'b0;
    chk("t5_resp_valid", 64'(resp_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_alu_a", 64'(alu_a), 64'd0);
    chk("t5_alu_b", 64'(alu_b), 64'd0);
    chk("t5_alu_op", 64'(alu_op), 64'd0);
    chk("t5_resp_data", 64'(resp_data), 64'd0);
    reset = 1'b0;
    req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'd0; req0_valid = 1'b1;
    req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'd3; req1_valid = 1'b1;
    #1;
    chk("t5_ptr_req0", 64'(req0_ready), 64'd1);
    chk("t5_ptr_req1", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Two-requester round-robin controller that shares the single combinational bit-slice ALU. It accepts an operation (A, B, op) from the granted requester and drives it onto the ALU. After a one-cycle settle, it captures the result and flags as a packed {overflow, zero, carry, result} word, matching the layout of the result/flag register. It then returns that word to the requester through a valid/ready response channel.

Parameters:
WIDTH, 32, ALU operand/result width
OPW, 3, ALU operation-select width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_op  input  OPW  requester 0 ALU op select
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
alu_a  output  WIDTH  operand A to ALU
alu_b  output  WIDTH  operand B to ALU
alu_op  output  OPW  op select to ALU
alu_result  input  WIDTH  ALU result (combinational)
alu_overflow  input  1  ALU overflow flag
alu_zero  input  1  ALU zero flag
alu_carry  input  1  ALU carry flag
resp_valid  output  1  response word available
resp_ready  input  1  consumer takes response
resp_id  output  1  requester index of the response
resp_data  output  WIDTH+3  {overflow, zero, carry, result}
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock port clk; reset port reset. Reset is synchronous and active-high; there is exactly one clock.
- Reset values: state=IDLE, priority pointer=0 (req0 favoured), alu_a/alu_b/alu_op=0, resp_valid=0, resp_id=0, resp_data=0, busy=0, req*_ready=0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational, asserted only for the granted N, and only when reqN_valid=1.
  - Grant rule: if only one requester is valid, it wins. If both are valid, the requester indicated by the pointer wins.
  - On handshake (valid & ready): latch a, b, op and the id into operand registers, flip the pointer to the other requester, and move to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* are driven from the operand registers.
  - At the end of the cycle, capture {alu_overflow, alu_zero, alu_carry, alu_result} into resp_data and the latched id into resp_id, then move to RESP.
- RESP:
  - resp_valid=1.
  - resp_data, resp_id and alu_* are held stable until resp_ready=1.
  - On resp_valid & resp_ready, move to IDLE; resp_valid drops in the next cycle.
- Latency: an accept in cycle T gives resp_valid high in cycle T+2. Minimum issue interval is 3 cycles with resp_ready tied high.
- Requests are never accepted in EXEC or RESP. A requester must hold valid and its operands until it sees ready.
- Pointer moves only on a grant; an idle requester never gains priority.
- Reset asserted mid-operation (EXEC or RESP): the operation is discarded, no response is produced, and all outputs return to reset values in the next cycle.
- A request that deasserts before being granted is not recorded.
- Flag packing places overflow at bit WIDTH+2, zero at bit WIDTH+1 and carry at bit WIDTH; result occupies bits WIDTH-1:0.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=0, EXEC=1, RESP=2), the flag bit-position constants (OVF_BIT, ZERO_BIT, CARRY_BIT) and the packed response width (WIDTH+3).
- One natural sub-module: rr_arb2, a two-request round-robin grant with pointer update on accept.
- The operand and response registers stay inline.

Test Plan:
1. The bench ALU model defines op 0 as ADD. req0 ADD A=5, B=3 with req1 idle -> req0_ready pulses one cycle; 2 cycles later resp_valid=1, resp_id=0, resp_data={0,0,0,32'h8}.
2. Both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1, each 3 cycles apart, with resp_id following the same sequence.
3. req1 ADD A=32'h7FFFFFFF, B=1 -> resp_data has overflow=1, zero=0, carry=0, result=32'h80000000. req0 ADD A=32'hFFFFFFFF, B=1 -> carry=1, zero=1, result=0.
4. resp_ready held 0 for 5 cycles with req0 valid -> resp_data/resp_id stable, req0_ready stays 0, busy=1. Raising resp_ready gives IDLE the next cycle, and req0 is then accepted.
5. reset asserted during EXEC -> next cycle resp_valid=0, busy=0, alu_*=0, pointer=0. No response ever appears for the aborted op.
